// File: rtl/tc_pkg.sv
// Shared threshold-cutter definitions: block geometry, tag source and FSM states.
// The block writer uses the same package so the address map and tag words agree.
package tc_pkg;

    localparam int unsigned BLOCK_NUM_INDEX   = 4;
    localparam int unsigned BLOCK_DEPTH_INDEX = 9;
    localparam int unsigned BLOCK_DEPTH       = 400;
    localparam int unsigned DATA_WIDTH        = 256;

    localparam logic [127:0] PRESET_SEQUENCE =
        128'h00_01_02_03_04_05_06_07_08_09_00_01_02_03_04_05;

    typedef logic [BLOCK_NUM_INDEX-1:0]   blk_t;
    typedef logic [BLOCK_DEPTH_INDEX-1:0] ptr_t;
    // One bit wider than ptr_t so BLOCK_DEPTH+1 and full burst sizes fit.
    typedef logic [BLOCK_DEPTH_INDEX:0]   cnt_t;
    typedef logic [DATA_WIDTH-1:0]        word_t;

    localparam ptr_t LAST_DATA_PTR = ptr_t'(BLOCK_DEPTH - 1);
    localparam ptr_t TAG_PTR       = ptr_t'(BLOCK_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        DONE
    } state_e;

    // Tag word stored after the data words of block blk.
    function automatic word_t tag_word(input blk_t blk);
        return {{(DATA_WIDTH - 1){1'b0}}, PRESET_SEQUENCE[7'(blk)]};
    endfunction

endpackage

// File: rtl/threshold_block_reader_if.sv
// AXI read-channel bundle (AR + R) between the block reader and the BRAM controller.
interface threshold_block_reader_if;
    import tc_pkg::*;

    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;

    logic [3:0]  s_axi_rid;
    word_t       s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        input  s_axi_rvalid
    );

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
        output s_axi_rvalid
    );

endinterface

// File: rtl/tc_out_reg.sv
// One-deep valid/ready output register carrying a data word and a last flag.
// in_ready is high when empty or when the held word leaves this cycle, so a
// continuous stream passes without bubbles.
module tc_out_reg import tc_pkg::*; #(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

    // Load on accepted input, otherwise empty once the held word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
            last_q  <= in_last;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/threshold_block_reader.sv
// Reads one block from the threshold-cutter BRAM over AXI INCR bursts, streams
// the BLOCK_DEPTH data words downstream and checks the trailing tag word.
module threshold_block_reader import tc_pkg::*; #(
    parameter int unsigned BURST_LEN = 16,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  blk_t                             block_sel,
    input  logic                             bram_busy,
    output logic                             busy,
    output logic                             done,
    output logic                             tag_ok,
    output logic                             resp_err,
    output word_t                            m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic                             m_last,
    threshold_block_reader_if.master         axi
);

    localparam cnt_t BURST = cnt_t'(BURST_LEN);
    localparam cnt_t TOTAL = cnt_t'(BLOCK_DEPTH + 1);

    state_e state_q, state_d;
    blk_t   blk_q, blk_d;
    ptr_t   word_ptr_q, word_ptr_d;
    cnt_t   beats_left_q, beats_left_d;
    logic   arvalid_q, arvalid_d;
    logic   resp_err_q, resp_err_d;
    logic   tag_hit_q, tag_hit_d;

    cnt_t   remaining;
    cnt_t   beats;
    logic   beat;
    logic   exp_last;
    logic   is_data;
    logic   out_in_ready;
    logic   unused_rid;

    // Words left in the block (data + tag) and the size of the next burst.
    assign remaining = TOTAL - cnt_t'(word_ptr_q);
    assign beats     = (remaining < BURST) ? remaining : BURST;

    // AR fields depend only on registers, so they stay put while arvalid waits.
    assign axi.s_axi_arid    = AXI_ID;
    assign axi.s_axi_araddr  = 32'({blk_q, word_ptr_q});
    assign axi.s_axi_arlen   = 8'(beats - cnt_t'(1));
    assign axi.s_axi_arsize  = 3'b101;
    assign axi.s_axi_arburst = 2'b01;
    assign axi.s_axi_arvalid = arvalid_q;

    assign axi.s_axi_rready = (state_q == DATA) && out_in_ready;

    assign beat       = axi.s_axi_rvalid && axi.s_axi_rready;
    assign exp_last   = (beats_left_q == cnt_t'(1));
    assign is_data    = (word_ptr_q < TAG_PTR);
    assign unused_rid = ^axi.s_axi_rid;

    assign busy     = (state_q == ADDR) || (state_q == DATA) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign tag_ok   = (state_q == DONE) && tag_hit_q;
    assign resp_err = resp_err_q;

    tc_out_reg #(
        .WIDTH(DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (beat && is_data),
        .in_data  (axi.s_axi_rdata),
        .in_last  (word_ptr_q == LAST_DATA_PTR),
        .in_ready (out_in_ready),
        .out_valid(m_valid),
        .out_data (m_data),
        .out_last (m_last),
        .out_ready(m_ready)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            blk_q        <= '0;
            word_ptr_q   <= '0;
            beats_left_q <= '0;
            arvalid_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            tag_hit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            word_ptr_q   <= word_ptr_d;
            beats_left_q <= beats_left_d;
            arvalid_q    <= arvalid_d;
            resp_err_q   <= resp_err_d;
            tag_hit_q    <= tag_hit_d;
        end
    end

    // Next-state: request bursts, count beats against the expected length, check tag.
    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        word_ptr_d   = word_ptr_q;
        beats_left_d = beats_left_q;
        arvalid_d    = arvalid_q;
        resp_err_d   = resp_err_q;
        tag_hit_d    = tag_hit_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ADDR;
                    blk_d      = block_sel;
                    word_ptr_d = '0;
                    resp_err_d = 1'b0;
                    tag_hit_d  = 1'b0;
                end
            end
            ADDR: begin
                if (!arvalid_q) begin
                    // Once raised, arvalid stays up until accepted even if bram_busy returns.
                    if (!bram_busy) begin
                        arvalid_d = 1'b1;
                    end
                end else if (axi.s_axi_arready) begin
                    arvalid_d    = 1'b0;
                    beats_left_d = beats;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    word_ptr_d   = word_ptr_q + 1'b1;
                    beats_left_d = beats_left_q - 1'b1;
                    if ((axi.s_axi_rresp != 2'b00) || (axi.s_axi_rlast != exp_last)) begin
                        resp_err_d = 1'b1;
                    end
                    if (!is_data) begin
                        tag_hit_d = (axi.s_axi_rdata == tag_word(blk_q));
                    end
                    if (exp_last) begin
                        state_d = is_data ? ADDR : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!m_valid || m_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
